// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV64M divide/remainder ops
module div_iter #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_end_valid,
    input  logic             i_end_ready,
    input  logic             i_divw,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic word, neg_q, neg_r;

    logic [WIDTH-1:0] ext_a, ext_b, abs_a, abs_b, min_v, q_fix, r_fix;
    logic neg_a, neg_b, div0, ovf, special, accept;
    logic [WIDTH:0] trial;

    assign ext_a   = i_divw ? {{H{i_signed & i_dividend[H-1]}}, i_dividend[H-1:0]} : i_dividend;
    assign ext_b   = i_divw ? {{H{i_signed & i_divisor[H-1]}}, i_divisor[H-1:0]} : i_divisor;
    assign neg_a   = i_signed & ext_a[WIDTH-1];
    assign neg_b   = i_signed & ext_b[WIDTH-1];
    assign abs_a   = neg_a ? -ext_a : ext_a;
    assign abs_b   = neg_b ? -ext_b : ext_b;
    assign min_v   = i_divw ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
    assign div0    = ext_b == '0;
    assign ovf     = i_signed && ext_a == min_v && &ext_b;
    assign special = div0 | ovf;
    assign accept  = state == IDLE && i_start && !i_flush;
    assign trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign q_fix   = neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem : rem;
    assign o_busy      = state != IDLE;
    assign o_end_valid = state == DONE;

    // next state; flush overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (special ? FIX : BUSY) : IDLE;
            BUSY:    state_nx = cnt == CW'(1) ? FIX : BUSY;
            FIX:     state_nx = DONE;
            DONE:    state_nx = i_end_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        if (i_flush) state_nx = IDLE;
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // operand capture, shift-subtract iterations and sign-corrected result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            word        <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            if (accept) begin
                word  <= i_divw;
                neg_q <= !special & (neg_a ^ neg_b);
                neg_r <= !special & neg_a;
                cnt   <= i_divw ? CW'(H) : CW'(WIDTH);
                dvs   <= abs_b;
                quo   <= div0 ? '1 : ovf ? ext_a : i_divw ? abs_a << H : abs_a;
                rem   <= div0 ? ext_a : '0;
            end else if (state == BUSY) begin
                rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], !trial[WIDTH]};
                cnt <= cnt - CW'(1);
            end
            if (state == FIX && !i_flush) begin
                o_quotient  <= word ? {{H{q_fix[H-1]}}, q_fix[H-1:0]} : q_fix;
                o_remainder <= word ? {{H{r_fix[H-1]}}, r_fix[H-1:0]} : r_fix;
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter against an arithmetic model
module tb_div_iter;
    logic clk = 1'b0;
    logic rst, flush, start, busy, end_valid, end_ready, divw, sgn;
    logic [63:0] dividend, divisor, quotient, remainder;
    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    div_iter #(.WIDTH(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_start(start),
        .o_busy(busy), .o_end_valid(end_valid), .i_end_ready(end_ready),
        .i_divw(divw), .i_signed(sgn), .i_dividend(dividend), .i_divisor(divisor),
        .o_quotient(quotient), .o_remainder(remainder)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic void model(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit sp);
        logic [31:0] a32, b32, q32, r32;
        int sa, sb;
        longint la, lb;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            sp = b32 == 0 || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (sp) begin q32 = a32; r32 = 0; end
            else if (s) begin sa = a32; sb = b32; q32 = sa / sb; r32 = sa % sb; end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            sp = b == 0 || (s && a == 64'h8000_0000_0000_0000 && b == '1);
            if (b == 0) begin q = '1; r = a; end
            else if (sp) begin q = a; r = 0; end
            else if (s) begin la = a; lb = b; q = la / lb; r = la % lb; end
            else begin q = a / b; r = a % b; end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pin(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] wq, input logic [63:0] wr);
        logic [63:0] q, r;
        bit sp;
        model(w, s, a, b, q, r, sp);
        chk("model_quotient", q, wq);
        chk("model_remainder", r, wr);
    endtask

    task automatic start_op(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                            output int lat);
        logic [63:0] q, r;
        bit sp;
        model(w, s, a, b, q, r, sp);
        lat = sp ? 1 : (w ? 33 : 65);
        divw = w; sgn = s; dividend = a; divisor = b; start = 1;
        step();
        start = 0;
        divw = $urandom_range(0, 1); sgn = $urandom_range(0, 1);
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        exp_q.push_back({q, r});
    endtask

    task automatic wait_valid(input int want_lat);
        int lat = 0;
        while (!end_valid && lat < 200) begin
            chk("busy_while_running", busy, 1);
            step();
            lat++;
        end
        chk("latency", lat, want_lat);
        chk("busy_at_valid", busy, 1);
    endtask

    task automatic run_op(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b, input int hold);
        int lat;
        start_op(w, s, a, b, lat);
        wait_valid(lat);
        for (int k = 0; k < hold; k++) begin
            start = $urandom_range(0, 1);
            dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
            step();
            chk("busy_hold", busy, 1);
            chk("valid_hold", end_valid, 1);
        end
        end_ready = 1; start = 1;
        step();
        end_ready = 0; start = 0;
        void'(exp_q.pop_front());
        chk("busy_after_handshake", busy, 0);
        chk("valid_after_handshake", end_valid, 0);
    endtask

    // scoreboard: every cycle with a valid result must show the oldest expected pair
    always @(negedge clk) begin
        if (end_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                chk("quotient", quotient, exp_q[0][127:64]);
                chk("remainder", remainder, exp_q[0][63:0]);
            end
        end
    end

    initial begin
        int lat;
        bit w, s;
        logic [63:0] a, b;
        rst = 1; flush = 0; start = 0; end_ready = 0; divw = 0; sgn = 0; dividend = 0; divisor = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", end_valid, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        rst = 0;

        pin(0, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        pin(0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        pin(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0);
        pin(1, 0, 64'hABCD_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        pin(0, 0, 64'd100, 64'd7, 64'd14, 64'd2);
        pin(0, 1, 64'd17, 64'd5, 64'd3, 64'd2);
        pin(1, 1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(0, 1, -64'sd7, 64'd2, 0);
        run_op(0, 0, 64'h1234, 64'd0, 0);
        run_op(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        run_op(1, 0, 64'hABCD_0000_FFFF_FFFF, 64'd1, 0);
        run_op(0, 0, 64'd100, 64'd7, 10);
        run_op(1, 1, 64'hFFFF_FFF9, 64'd2, 2);

        start_op(0, 0, {$urandom, $urandom}, 64'd12345, lat);
        repeat (20) step();
        flush = 1;
        step();
        flush = 0;
        void'(exp_q.pop_front());
        chk("flush_busy", busy, 0);
        chk("flush_valid", end_valid, 0);
        run_op(0, 1, 64'd17, 64'd5, 0);

        start = 1; flush = 1; divw = 0; sgn = 0; dividend = 64'd9; divisor = 64'd3;
        step();
        start = 0; flush = 0;
        chk("flush_start_busy", busy, 0);
        step();
        chk("flush_start_busy_later", busy, 0);

        start_op(0, 0, 64'd55, 64'd0, lat);
        wait_valid(lat);
        flush = 1; end_ready = 1;
        step();
        flush = 0; end_ready = 0;
        void'(exp_q.pop_front());
        chk("flush_done_busy", busy, 0);
        chk("flush_done_valid", end_valid, 0);
        chk("flush_keeps_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);

        start_op(0, 1, 64'd1000, 64'd3, lat);
        repeat (10) step();
        rst = 1;
        step();
        rst = 0;
        void'(exp_q.pop_front());
        chk("rst_busy_busy", busy, 0);
        chk("rst_busy_valid", end_valid, 0);
        chk("rst_busy_quotient", quotient, 0);
        chk("rst_busy_remainder", remainder, 0);

        start_op(1, 0, 64'd77, 64'd5, lat);
        wait_valid(lat);
        rst = 1;
        step();
        rst = 0;
        void'(exp_q.pop_front());
        chk("rst_done_busy", busy, 0);
        chk("rst_done_valid", end_valid, 0);
        chk("rst_done_quotient", quotient, 0);
        chk("rst_done_remainder", remainder, 0);

        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 1);
            s = $urandom_range(0, 1);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = '1;
                2: b = b >> $urandom_range(1, 62);
                3: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
                default: ;
            endcase
            run_op(w, s, a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
